// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder slice.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mm_state_t;

  localparam int MM_WORD_W         = 32;
  localparam int MM_CNT_W          = 4;
  localparam int MM_DEF_LATENCY    = 4;
  localparam int MM_DEF_DEPTH_LOG2 = 10;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-to-main-memory request port; the cache is the master, the responder the slave.
interface main_mem_responder_if;
  import main_mem_pkg::*;

  logic                 mem_ren;
  logic                 mem_wen;
  logic [MM_WORD_W-1:0] mem_addr;
  logic [MM_WORD_W-1:0] mem_din;
  logic [MM_WORD_W-1:0] mem_dout;
  logic                 mem_rdy;
  logic                 mem_busy;
  logic                 req_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_din,
    input  mem_dout, mem_rdy, mem_busy, req_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_din,
    output mem_dout, mem_rdy, mem_busy, req_err
  );

endinterface

// File: rtl/main_mem_array.sv
// Single-port synchronous word RAM; the read register resets to zero and only moves on reads.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = MM_DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [MM_WORD_W-1:0]  wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [MM_WORD_W-1:0]  rdata
);

  logic [MM_WORD_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Backing-memory responder: accepts one cache request, waits LATENCY cycles, pulses mem_rdy.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int LATENCY    = MM_DEF_LATENCY,
  parameter int DEPTH_LOG2 = MM_DEF_DEPTH_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  main_mem_responder_if.slave mem
);

  localparam logic [MM_CNT_W-1:0] CNT_LOAD = MM_CNT_W'(LATENCY - 1);

  mm_state_t             state;
  mm_state_t             next_state;
  logic [MM_CNT_W-1:0]   cnt;
  logic                  op_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic [MM_WORD_W-1:0]  wdata;
  logic                  req_err_q;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic [DEPTH_LOG2-1:0] array_addr;
  logic                  array_we;
  logic                  array_re;
  logic [MM_WORD_W-1:0]  array_rdata;
  logic                  unused_addr;

  // Byte offset and aliasing bits of the address are intentionally dropped.
  assign in_idx      = mem.mem_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{mem.mem_addr[1:0], mem.mem_addr[MM_WORD_W-1:DEPTH_LOG2+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      req_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt      <= CNT_LOAD;
        op_write <= mem.mem_wen;
        idx      <= in_idx;
        wdata    <= mem.mem_din;
        if (mem.mem_ren && mem.mem_wen) begin
          req_err_q <= 1'b1;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // The read is issued on the edge entering DONE so data is already valid while mem_rdy is high;
  // with a one-cycle latency that edge is the acceptance edge, so the live address is used.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    array_re   = 1'b0;
    array_we   = 1'b0;
    array_addr = idx;
    case (state)
      IDLE: begin
        array_addr = in_idx;
        if (mem.mem_ren || mem.mem_wen) begin
          accept     = 1'b1;
          next_state = (LATENCY == 1) ? DONE : WAIT;
          array_re   = (LATENCY == 1) && !mem.mem_wen;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          next_state = DONE;
          array_re   = !op_write;
        end
      end
      DONE: begin
        next_state = IDLE;
        array_we   = op_write;
      end
      default: next_state = IDLE;
    endcase
  end

  main_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .addr (array_addr),
    .wdata(wdata),
    .we   (array_we),
    .re   (array_re),
    .rdata(array_rdata)
  );

  assign mem.mem_dout = array_rdata;
  assign mem.mem_rdy  = (state == DONE);
  assign mem.mem_busy = (state != IDLE);
  assign mem.req_err  = req_err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: scoreboard of expected completions, checked at each mem_rdy.
module tb_main_mem_responder;

  localparam int DL2 = 10;
  localparam int LAT = 4;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } sb_item_t;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] din;
  logic        sel1;

  logic        obs_rdy;
  logic        obs_busy;
  logic        obs_err;
  logic [31:0] obs_dout;

  int checks   = 0;
  int failures = 0;

  sb_item_t    sb[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_dout;
  logic        model_req_err;

  main_mem_responder_if bus4 ();
  main_mem_responder_if bus1 ();

  assign bus4.mem_ren  = ren;
  assign bus4.mem_wen  = wen;
  assign bus4.mem_addr = addr;
  assign bus4.mem_din  = din;
  assign bus1.mem_ren  = ren;
  assign bus1.mem_wen  = wen;
  assign bus1.mem_addr = addr;
  assign bus1.mem_din  = din;

  main_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut4 (
    .clk(clk),
    .rst(rst),
    .mem(bus4)
  );

  main_mem_responder #(.LATENCY(1), .DEPTH_LOG2(DL2)) dut1 (
    .clk(clk),
    .rst(rst),
    .mem(bus1)
  );

  assign obs_rdy  = sel1 ? bus1.mem_rdy  : bus4.mem_rdy;
  assign obs_busy = sel1 ? bus1.mem_busy : bus4.mem_busy;
  assign obs_err  = sel1 ? bus1.req_err  : bus4.req_err;
  assign obs_dout = sel1 ? bus1.mem_dout : bus4.mem_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one request at a gap negedge, holds it until mem_rdy, then idles one gap cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    sb_item_t item;
    int       word;
    int       k;
    int       exp_lat;
    bit       done;
    word    = int'(a[DL2+1:2]);
    exp_lat = sel1 ? 1 : LAT;
    item.is_read = rd && !wr;
    if (wr) begin
      model_mem[word] = d;
      item.data = model_dout;
      if (rd) model_req_err = 1'b1;
    end else begin
      item.data  = model_mem[word];
      model_dout = item.data;
    end
    sb.push_back(item);
    ren  = rd;
    wen  = wr;
    addr = a;
    din  = d;
    @(posedge clk);
    k    = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (obs_rdy === 1'b1) begin
        done = 1'b1;
        ren  = 1'b0;
        wen  = 1'b0;
        item = sb.pop_front();
        checkOutput("rdy_latency", 32'(k), 32'(exp_lat));
        checkOutput("busy_at_rdy", 32'(obs_busy), 32'd1);
        checkOutput(item.is_read ? "read_data" : "dout_after_write", obs_dout, item.data);
      end else begin
        checkOutput("busy_wait", 32'(obs_busy), 32'd1);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL rdy_timeout observed=no_rdy expected=rdy_within_20");
      ren = 1'b0;
      wen = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    sb_item_t item;
    sel1          = 1'b0;
    rst           = 1'b1;
    ren           = 1'b0;
    wen           = 1'b0;
    addr          = '0;
    din           = '0;
    model_dout    = '0;
    model_req_err = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rdy",  32'(obs_rdy),  32'd0);
    checkOutput("reset_busy", 32'(obs_busy), 32'd0);
    checkOutput("reset_dout", obs_dout,      32'h0);
    checkOutput("reset_err",  32'(obs_err),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] write then read 0x40");
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);

    $display("[TB] held read across mem_rdy");
    item.is_read = 1'b1;
    item.data    = model_mem[16];
    sb.push_back(item);
    sb.push_back(item);
    ren  = 1'b1;
    addr = 32'h40;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput("held_rdy",  32'(obs_rdy),  32'((k % 5) == 4));
      checkOutput("held_busy", 32'(obs_busy), 32'((k % 5) != 0));
      if (obs_rdy === 1'b1 && sb.size() > 0) begin
        item = sb.pop_front();
        checkOutput("held_read_data", obs_dout, item.data);
      end
      if (k == 9) ren = 1'b0;
    end
    checkOutput("held_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    $display("[TB] address aliasing");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 32'(1 << (DL2 + 2)), 32'h22222222);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5);
    checkOutput("req_err_set", 32'(obs_err), 32'(model_req_err));
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
    checkOutput("req_err_sticky", 32'(obs_err), 32'(model_req_err));

    $display("[TB] reset during write wait");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h12345678);
    wen  = 1'b1;
    addr = 32'h10;
    din  = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_before_rst", 32'(obs_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    wen           = 1'b0;
    model_dout    = '0;
    model_req_err = 1'b0;
    checkOutput("rst_mid_rdy",  32'(obs_rdy),  32'd0);
    checkOutput("rst_mid_busy", 32'(obs_busy), 32'd0);
    checkOutput("rst_mid_dout", obs_dout,      32'h0);
    checkOutput("rst_mid_err",  32'(obs_err),  32'(model_req_err));
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);

    $display("[TB] latency one read");
    repeat (3) @(negedge clk);
    sel1 = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Word-addressed backing-memory model and controller that answers the cache's main-memory request port (`mem_ren`, `mem_wen`, `mem_addr`, `mem_din`, `mem_dout`) after a programmable latency. It is the responder for the cache's miss/write-back initiator and sits beside the cache instance under the top level. Completion is signalled by a one-cycle `mem_rdy` pulse, which the cache waits on before releasing its request.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `mem_rdy`; legal range 1..15.
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words stored.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_ren`  in  1  read request from cache; level, held until `mem_rdy`.
- `mem_wen`  in  1  write request from cache; level, held until `mem_rdy`.
- `mem_addr`  in  32  byte address; bits [1:0] ignored, bits [DEPTH_LOG2+1:2] select the word, higher bits ignored (aliasing).
- `mem_din`  in  32  write data from cache.
- `mem_dout`  out  32  read data to cache.
- `mem_rdy`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  high while a request is in flight.
- `req_err`  out  1  sticky; set when `mem_ren` and `mem_wen` are sampled high together at acceptance.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: if `mem_ren | mem_wen`, latch the word index, `mem_din` and the op (write wins if both are high, and `req_err` is set), load the counter with `LATENCY-1`, and go to WAIT. If `LATENCY==1`, go directly to DONE.
- WAIT: the counter decrements each cycle; at 1 go to DONE. Request inputs are ignored, and changes to `mem_addr`/`mem_din` have no effect.
- DONE: `mem_rdy=1` for exactly this cycle.
  - A write commits the latched data to the array at the end of this cycle.
  - For a read, `mem_dout` holds the array word (registered) from this cycle on.
  - Then go to IDLE. Request inputs in DONE are ignored, so a held request is not re-accepted.
- `mem_dout` retains the last read value until the next read completes; writes do not change it.
- Array contents are not reset. Reads of never-written words return X in simulation, and the bench must not rely on them.
- Counter width is 4 bits; no wrap occurs within the legal LATENCY range.

## Timing
- Reset values: `mem_rdy=0`, `mem_busy=0`, `mem_dout=0`, `req_err=0`, state IDLE, counter 0.
- Acceptance: the request is sampled at edge N while in IDLE. `mem_busy` is high from cycle N+1 through the DONE cycle. `mem_rdy` is high in cycle N+LATENCY.
- Back-to-back: the earliest next acceptance is the edge ending the cycle after `mem_rdy` (minimum period LATENCY+1 cycles).
- Read-after-write to the same word: the write commits at the DONE edge, so the following read returns the new data.
- Reset mid-operation: `rst` high at any edge returns the block to IDLE and clears outputs. A write not yet at DONE is discarded, and the array is untouched.
- `req_err` clears only on `rst`.

## Structure
- Package `main_mem_pkg`:
  - state enum `mm_state_t` {IDLE, WAIT, DONE}
  - `MM_WORD_W=32`
  - `MM_CNT_W=4`
  - default LATENCY/DEPTH_LOG2 constants
- Sub-module `main_mem_array`: single-port synchronous RAM, 2^DEPTH_LOG2 × 32, with registered read and write enable. It is instantiated once, and the FSM drives its address, data and enable signals.

## Test plan
- Reset, then write 0xDEADBEEF to 0x40, then read 0x40 → `mem_rdy` exactly 4 cycles after each acceptance, and `mem_dout`=0xDEADBEEF in the read's `mem_rdy` cycle.
- Hold `mem_ren` high across `mem_rdy` with addr 0x40 → exactly one `mem_rdy` pulse per acceptance, with a one-cycle gap between accepts, and `mem_busy` low only in the gap cycles.
- Write 0x11111111 to 0x0, then 0x22222222 to addr `(1<<(DEPTH_LOG2+2))`, then read 0x0 → 0x22222222 (aliasing).
- Assert `mem_ren` and `mem_wen` together with data 0xA5A5A5A5 at 0x8 → treated as a write, `req_err`=1 and stays 1, and a subsequent read of 0x8 returns 0xA5A5A5A5.
- Start a write of 0xCAFEF00D to 0x10 over a prior 0x12345678, and pulse `rst` in the WAIT state → outputs return to reset values, and a later read of 0x10 returns 0x12345678.
- With LATENCY=1, issue a read → `mem_rdy` in the cycle immediately after acceptance.
